// File: rtl/rr_mux_pkg.sv
// Shared constants for the rr_mux_arb channel multiplexer.
package rr_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   XFER_CNT_W = 16;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set req at or after ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N:1 valid/ready mux, fixed-select or round-robin, 1-cycle registered output; stalls all inputs
// while the output word is held. Optional per-channel transfer counters under RR_MUX_XFER_CNT_EN.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int DW    = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef RR_MUX_XFER_CNT_EN
  input  logic               clr_cnt,
  output logic [N_CH*16-1:0] xfer_cnt,
`endif
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_valid,
  output logic [N_CH-1:0]    in_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_ch
);

  logic [SEL_W-1:0]        ptr;
  logic                    rr_vld;
  logic [SEL_W-1:0]        rr_idx;
  logic                    gnt_vld;
  logic [SEL_W-1:0]        gnt_idx;
  logic [(1<<SEL_W)-1:0]   vld_ext;
  logic                    load;
  logic                    xfer;

  rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Zero-padded valid vector lets an out-of-range sel index safely and grant nothing.
  always_comb begin
    vld_ext = '0;
    vld_ext[N_CH-1:0] = in_valid;
    if (mode == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else begin
      gnt_vld = vld_ext[sel] && (int'(sel) < N_CH);
      gnt_idx = sel;
    end
  end

  assign load = !out_valid || out_ready;
  assign xfer = rst_n && load && gnt_vld;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx*DW +: DW];
      out_ch    <= gnt_idx;
      if (mode == MODE_RR)
        ptr <= (gnt_idx == SEL_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_MUX_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] cnt [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr_cnt)
          cnt[i] <= '0;
        else if (in_ready[i] && in_valid[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    xfer_cnt = '0;
    for (int i = 0; i < N_CH; i++) xfer_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule
